// File: rtl/btn_demux.sv
// btn_demux: debounces one pushbutton and routes its press pulse and held level to a selected channel
// ports: clk; rst_n async active-low reset; btn_raw raw bouncy pin; sel destination (sampled at press accept);
//        pulse_out one-cycle press pulse and level_out held level on the latched channel;
//        busy FSM not idle; drop one-cycle pulse when a press is accepted with sel >= N_OUT
module btn_demux #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int N_OUT = 2,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_raw,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] pulse_out,
  output logic [N_OUT-1:0] level_out,
  output logic             busy,
  output logic             drop
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] SAT = CW'(DEBOUNCE_CYCLES);
  localparam logic [SEL_W:0] NO = (SEL_W + 1)'(N_OUT);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  state_t state, nxt;
  logic s1, s2, accept, match, sel_ok, selq_ok;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] sel_q;
  always_comb begin
    nxt = state;
    accept = 1'b0;
    case (state)
      IDLE: nxt = s2 ? PRESS_WAIT : IDLE;
      PRESS_WAIT: begin
        if (!s2) nxt = IDLE;
        else if (cnt == LAST) begin
          nxt = HELD;
          accept = 1'b1;
        end
      end
      HELD: nxt = s2 ? HELD : RELEASE_WAIT;
      RELEASE_WAIT: begin
        if (s2) nxt = HELD;
        else if (cnt == LAST) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    match = (state == PRESS_WAIT) ? s2 : (state == RELEASE_WAIT) ? !s2 : 1'b0;
    // any mismatch or state change restarts the stability count; it saturates rather than wraps
    cnt_nxt = (nxt != state || !match) ? '0 : (cnt == SAT) ? cnt : cnt + 1'b1;
    sel_ok = {1'b0, sel} < NO;
    selq_ok = {1'b0, sel_q} < NO;
  end
  assign busy = state != IDLE;
  assign level_out = ((state == HELD || state == RELEASE_WAIT) && selq_ok) ? N_OUT'(1) << sel_q : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      sel_q <= '0;
      pulse_out <= '0;
      drop <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      state <= nxt;
      cnt <= cnt_nxt;
      sel_q <= accept ? sel : sel_q;
      pulse_out <= (accept && sel_ok) ? N_OUT'(1) << sel : '0;
      drop <= accept && !sel_ok;
    end
  end
endmodule

// File: tb/tb_btn_demux.sv
// tb_btn_demux: checks two btn_demux instances (N_OUT=4 and N_OUT=3) against a run-length debounce model
module tb_btn_demux;
  localparam int D = 4;
  logic clk = 1'b0, rst_n = 1'b1, btn_raw = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] pulse4, level4;
  logic [2:0] pulse3, level3;
  logic busy4, drop4, busy3, drop3;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  btn_demux #(.DEBOUNCE_CYCLES(D), .N_OUT(4)) dut4 (.clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sel(sel),
    .pulse_out(pulse4), .level_out(level4), .busy(busy4), .drop(drop4));
  btn_demux #(.DEBOUNCE_CYCLES(D), .N_OUT(3)) dut3 (.clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sel(sel),
    .pulse_out(pulse3), .level_out(level3), .busy(busy3), .drop(drop3));
  // reference: the accepted level flips once D+1 consecutive synchronized samples disagree with it
  bit d1, d2, acc, md3;
  int run;
  logic [1:0] selq;
  logic [3:0] mp4;
  logic [2:0] mp3;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 = 0; d2 = 0; acc = 0; run = 0; selq = 0; mp4 = 0; mp3 = 0; md3 = 0;
    end else begin
      mp4 = 0; mp3 = 0; md3 = 0;
      if (d2 != acc) begin
        run++;
        if (run == D + 1) begin
          acc = !acc;
          run = 0;
          if (acc) begin
            selq = sel;
            mp4 = 4'(1) << sel;
            if (sel < 3) mp3 = 3'(1) << sel;
            else md3 = 1;
          end
        end
      end else run = 0;
      d2 = d1;
      d1 = btn_raw;
    end
  end
  function automatic logic [17:0] obs();
    return {pulse4, level4, busy4, drop4, pulse3, level3, busy3, drop3};
  endfunction
  function automatic logic [17:0] expv();
    logic [3:0] l4;
    logic [2:0] l3;
    logic b;
    l4 = acc ? 4'(1) << selq : 4'd0;
    l3 = (acc && selq < 3) ? 3'(1) << selq : 3'd0;
    b = acc || run > 0;
    return {mp4, l4, b, 1'b0, mp3, l3, b, md3};
  endfunction
  task automatic drive(input logic b, input logic [1:0] s);
    btn_raw = b;
    sel = s;
    @(negedge clk);
  endtask
  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (obs() !== 18'd0) begin errors++; $display("FAIL reset got=%h exp=0", obs()); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'(i));
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs(), expv()); end
    end
  endtask
  task automatic test_clean_press();
    int pulse_at = -1, npulse = 0, fall_at = -1, nbusy = 0;
    for (int i = 0; i < 30; i++) begin
      drive(i < 20, 2'd2);
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL clean cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      if (pulse4 != 0) begin npulse++; if (pulse_at < 0 && pulse4 == 4'b0100) pulse_at = i; end
      if (i >= 20 && fall_at < 0 && level4 == 0) fall_at = i;
      if (busy4) nbusy++;
    end
    checks++; if (pulse_at !== 6) begin errors++; $display("FAIL clean_pulse_time got=%0d exp=6", pulse_at); end
    checks++; if (npulse !== 1) begin errors++; $display("FAIL clean_pulse_count got=%0d exp=1", npulse); end
    checks++; if (fall_at !== 26) begin errors++; $display("FAIL clean_level_fall got=%0d exp=26", fall_at); end
    checks++; if (nbusy !== 24) begin errors++; $display("FAIL clean_busy_span got=%0d exp=24", nbusy); end
  endtask
  task automatic test_bounce();
    logic [19:0] pat = 20'b0000_0000_0000_1110_1110;
    int npulse = 0;
    logic [3:0] lv = 0;
    for (int i = 0; i < 20; i++) begin
      drive(pat[i], 2'($urandom_range(0, 3)));
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL bounce cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      if (pulse4 != 0 || drop3) npulse++;
      lv |= level4;
    end
    checks++; if (npulse !== 0 || lv !== 4'd0) begin errors++; $display("FAIL bounce_quiet got=%0d/%b exp=0/0000", npulse, lv); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL bounce_idle got=%b exp=0", busy4); end
  endtask
  task automatic test_sel_latch();
    logic [3:0] pm = 0, lm = 0;
    int npulse = 0;
    bit held_ok = 1;
    for (int i = 0; i < 44; i++) begin
      drive(i < 30 && !(i == 15 || i == 16), i < 8 ? 2'd1 : 2'd3);
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL latch cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      pm |= pulse4;
      lm |= level4;
      if (pulse4 != 0) npulse++;
      if (i >= 6 && i <= 35 && level4 != 4'b0010) held_ok = 0;
    end
    checks++; if (pm !== 4'b0010 || lm !== 4'b0010) begin errors++; $display("FAIL latch_channel got=%b/%b exp=0010/0010", pm, lm); end
    checks++; if (npulse !== 1) begin errors++; $display("FAIL latch_pulse_count got=%0d exp=1", npulse); end
    checks++; if (!held_ok) begin errors++; $display("FAIL latch_level_held got=0 exp=1"); end
  endtask
  task automatic test_out_of_range();
    int ndrop = 0, nbusy = 0;
    logic [2:0] om = 0;
    for (int i = 0; i < 25; i++) begin
      drive(i < 15, 2'd3);
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL oor cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      if (drop3) ndrop++;
      if (busy3) nbusy++;
      om |= pulse3 | level3;
    end
    checks++; if (ndrop !== 1) begin errors++; $display("FAIL oor_drop_count got=%0d exp=1", ndrop); end
    checks++; if (om !== 3'd0) begin errors++; $display("FAIL oor_outputs got=%b exp=000", om); end
    checks++; if (nbusy !== 19) begin errors++; $display("FAIL oor_busy_span got=%0d exp=19", nbusy); end
  endtask
  task automatic test_reset_mid_hold();
    logic [1:0] s = 2'($urandom_range(0, 3));
    int npulse = 0, pulse_at = -1;
    for (int i = 0; i < 10; i++) drive(1'b1, s);
    checks++; if (level4 !== 4'(1) << s) begin errors++; $display("FAIL rst_pre_held got=%b exp=%b", level4, 4'(1) << s); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (obs() !== 18'd0) begin errors++; $display("FAIL rst_async got=%h exp=0", obs()); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(i < 12, s);
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL rst_rehold cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      if (pulse4 != 0) begin npulse++; if (pulse_at < 0) pulse_at = i; end
    end
    checks++; if (npulse !== 1 || pulse_at !== 6) begin errors++; $display("FAIL rst_repress got=%0d@%0d exp=1@6", npulse, pulse_at); end
  endtask
  task automatic test_back_to_back();
    logic [1:0] a = 2'($urandom_range(0, 3)), b = 2'($urandom_range(0, 3));
    int np = 0;
    int at [2] = '{-1, -1};
    logic [3:0] pv [2] = '{4'd0, 4'd0};
    for (int i = 0; i < 30; i++) begin
      drive(i < 5 || (i >= 10 && i < 15), i < 11 ? a : b);
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL b2b cyc=%0d got=%h exp=%h", i, obs(), expv()); end
      if (pulse4 != 0) begin
        if (np < 2) begin at[np] = i; pv[np] = pulse4; end
        np++;
      end
    end
    checks++; if (np !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", np); end
    checks++; if (at[0] !== 6 || pv[0] !== 4'(1) << a) begin errors++; $display("FAIL b2b_first got=%b@%0d exp=%b@6", pv[0], at[0], 4'(1) << a); end
    checks++; if (at[1] !== 16 || pv[1] !== 4'(1) << b) begin errors++; $display("FAIL b2b_second got=%b@%0d exp=%b@16", pv[1], at[1], 4'(1) << b); end
  endtask
  task automatic test_random();
    logic b = 0;
    int left = 0;
    for (int i = 0; i < 800; i++) begin
      if (left == 0) begin b = !b; left = $urandom_range(1, 9); end
      left--;
      drive(b, 2'($urandom_range(0, 3)));
      checks++; if (obs() !== expv()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs(), expv()); end
    end
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_sel_latch();
    test_out_of_range();
    test_reset_mid_hold();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/btn_demux.md
# btn_demux

Routes a single mechanical pushbutton to one of `N_OUT` consumer channels on the Basys-3 ADC board. It synchronizes and debounces the raw pin, latches the channel select at the moment a press is accepted, and emits a one-cycle press pulse plus a held level on the selected channel only. It is the inverse of the board's button multiplexer: one physical source fans out to many logical destinations, for example "start conversion", "cycle display mode" or "clear".

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept an edge (10 ms at 100 MHz). Must be ≥ 1.
- `N_OUT`, default 2: number of output channels. Must be ≥ 2.
- `SEL_W`, default `$clog2(N_OUT)`: select width. Derived; not overridden.

**Ports**
- `clk` input 1: system clock, 100 MHz.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_raw` input 1: raw pushbutton pin, asynchronous, active-high, bouncy.
- `sel` input `SEL_W`: destination channel. Sampled only when a press is accepted.
- `pulse_out` output `N_OUT`: one-cycle pulse on bit `sel_q` at press acceptance.
- `level_out` output `N_OUT`: bit `sel_q` high from press acceptance until release is accepted.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `drop` output 1: one-cycle pulse when a press is accepted with `sel >= N_OUT`.

## Operation

**Synchronizer**
- `btn_raw` passes through two flops (`s1`, `s2`). Only `s2` is used downstream.

**Debounce counter**
- `cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits wide.
- It increments each cycle that `s2` matches the level the FSM is waiting for.
- It clears to 0 on any mismatch and on every state change.
- It never wraps; it saturates at `DEBOUNCE_CYCLES`.

**FSM states**
- IDLE: wait for `s2`=1. On `s2`=1 go to PRESS_WAIT. `cnt` is 0 here.
- PRESS_WAIT: count while `s2`=1.
  - If `s2`=0, return to IDLE (bounce rejected).
  - When `cnt` = `DEBOUNCE_CYCLES-1` and `s2`=1, accept the press and go to HELD.
  - On acceptance, latch `sel_q <= sel`.
- HELD: wait for `s2`=0. On `s2`=0 go to RELEASE_WAIT.
- RELEASE_WAIT: count while `s2`=0.
  - If `s2`=1, return to HELD (bounce rejected; no new pulse).
  - When `cnt` = `DEBOUNCE_CYCLES-1` and `s2`=0, go to IDLE.

**Outputs**
- `pulse_out[sel_q]` is registered high for exactly the one cycle after the HELD transition. All other bits stay 0.
- `level_out[sel_q]` is high in HELD and RELEASE_WAIT. It falls on the cycle the FSM registers IDLE.
- If the latched `sel_q >= N_OUT`: `pulse_out` and `level_out` stay all-zero, `drop` pulses once, and the FSM still runs HELD/RELEASE_WAIT normally.
- `sel` changes while not in IDLE/PRESS_WAIT are ignored; `sel_q` holds.
- At most one bit of `pulse_out` and one bit of `level_out` is ever high.

**Reset**
- `rst_n` low, at any time and in any state, forces the following immediately:
  - `s1`, `s2`, `cnt`, `sel_q` to 0.
  - State to IDLE.
  - `pulse_out`, `level_out`, `busy`, `drop` to 0.
- A button held through reset release must be re-debounced as a new press: one pulse after `2+DEBOUNCE_CYCLES` cycles.

## Timing

- **Press latency:** `btn_raw` clean high first sampled at edge k gives `s2`=1 after edge k+1. `pulse_out` is high during the cycle after edge k+1+`DEBOUNCE_CYCLES`+1. Total is 2+`DEBOUNCE_CYCLES` cycles from the first sampling edge.
- **Release latency:** the same count applies from the first low sample to `level_out` falling.
- **Minimum repeat interval** between two accepted presses: 2×`DEBOUNCE_CYCLES`+2 cycles.
- **Glitches:** any high glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` produces no output. Any low glitch shorter than that while held does not drop `level_out`.
- **Output timing:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4 and `N_OUT`=4.

- **Clean press:** `sel`=2, `btn_raw` 0→1 held 20 cycles then 0 → `pulse_out`=4'b0100 for 1 cycle, 6 cycles after the first high sample. `level_out[2]` falls 6 cycles after the first low sample. `busy` covers the whole span.
- **Bounce rejection:** `btn_raw` toggles 1,0,1,1,0 (each ≤3 cycles), then stays 0 → no pulse, `level_out`=0, FSM returns to IDLE.
- **Select latch:** press with `sel`=1, change `sel` to 3 while held → only `pulse_out[1]` and `level_out[1]` are ever active. Release bounce of 2 low cycles mid-hold → `level_out[1]` stays high and no second pulse occurs.
- **Out-of-range select:** `N_OUT`=3, `sel`=3, clean press → `drop`=1 for 1 cycle, `pulse_out`=`level_out`=0, `busy` behaves normally.
- **Reset mid-hold:** assert `rst_n`=0 while in HELD with `btn_raw`=1 → all outputs 0 asynchronously. Release reset with the button still high → exactly one new pulse 6 cycles after release.
- **Back-to-back presses:** two clean presses separated by 5 low cycles → two pulses on the respective latched `sel` values.
